// File: rtl/rom_fetch_seq.sv
// Fetch sequencer for a one-cycle-latency synchronous ROM. It reads len words from
// start_addr and streams them out through a small credit-checked FIFO.
module rom_fetch_seq #(
  parameter int unsigned AW    = 4,
  parameter int unsigned DW    = 16,
  parameter int unsigned DEPTH = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW-1:0] start_addr,
  input  logic [AW:0]   len,
  input  logic          abort,
  output logic          rom_en,
  output logic [AW-1:0] rom_addr,
  input  logic [DW-1:0] rom_dout,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  input  logic          out_ready,
  output logic          busy,
  output logic          done
);

  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {StIdle, StFetch, StDrain} state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   ptr_q, ptr_d;
  logic [AW:0]     remaining_q, remaining_d;
  logic [CntW-1:0] cnt_q, cnt_d, cnt_after_pop;
  logic            rom_pend_q, rom_pend_d;
  logic            done_zero_q, done_zero_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] fill_q, fill_d;
  logic [DW-1:0]   mem_q [DEPTH];
  logic            issue, pop, push, last_pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(DEPTH - 1)) ? '0 : p + PtrW'(1);
  endfunction

  assign out_valid     = (fill_q != '0);
  assign out_data      = mem_q[rd_ptr_q];
  assign pop           = out_valid & out_ready;
  assign push          = rom_pend_q & ~abort;
  assign cnt_after_pop = cnt_q - CntW'(pop);
  // Credit check: a read only issues if its word is guaranteed a FIFO slot.
  assign issue = (state_q == StFetch) && (remaining_q != '0) &&
                 (cnt_after_pop < CntW'(DEPTH)) && !abort;
  // In DRAIN the only outstanding word is the one leaving now.
  assign last_pop = (state_q == StDrain) && pop && (cnt_q == CntW'(1)) && !abort;

  assign rom_en   = issue;
  assign rom_addr = ptr_q;
  assign busy     = (state_q != StIdle);
  assign done     = done_zero_q | last_pop;

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    remaining_d = remaining_q;
    done_zero_d = 1'b0;
    rom_pend_d  = issue;
    cnt_d       = cnt_after_pop + CntW'(issue);

    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (len != '0) begin
            state_d     = StFetch;
            ptr_d       = start_addr;
            remaining_d = len;
          end else begin
            done_zero_d = 1'b1;
          end
        end
      end
      StFetch: begin
        if (issue && remaining_q == (AW+1)'(1)) state_d = StDrain;
      end
      StDrain: begin
        if (cnt_d == '0) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (issue) begin
      ptr_d       = ptr_q + AW'(1);
      remaining_d = remaining_q - (AW+1)'(1);
    end

    if (abort) begin
      state_d     = StIdle;
      ptr_d       = ptr_q;
      remaining_d = '0;
      cnt_d       = '0;
      rom_pend_d  = 1'b0;
      done_zero_d = 1'b0;
    end
  end

  always_comb begin
    fill_d   = fill_q + CntW'(push) - CntW'(pop);
    wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    if (abort) begin
      fill_d   = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      ptr_q       <= '0;
      remaining_q <= '0;
      cnt_q       <= '0;
      rom_pend_q  <= 1'b0;
      done_zero_q <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      fill_q      <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      remaining_q <= remaining_d;
      cnt_q       <= cnt_d;
      rom_pend_q  <= rom_pend_d;
      done_zero_q <= done_zero_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      fill_q      <= fill_d;
    end
  end

  // Storage is reset so out_data reads zero out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else if (push) begin
      mem_q[wr_ptr_q] <= rom_dout;
    end
  end

endmodule

// File: tb/tb_rom_fetch_seq.sv
// Bench for rom_fetch_seq: a behavioural ROM feeds the DUT, and expected words are queued
// at each start and matched against the words popped from the output stream.
module tb_rom_fetch_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [3:0]  start_addr;
  logic [4:0]  len;
  logic        abort;
  logic        rom_en;
  logic [3:0]  rom_addr;
  logic [15:0] rom_dout;
  logic        out_valid;
  logic [15:0] out_data;
  logic        out_ready;
  logic        busy;
  logic        done;

  rom_fetch_seq #(.AW(4), .DW(16), .DEPTH(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .start_addr (start_addr),
    .len        (len),
    .abort      (abort),
    .rom_en     (rom_en),
    .rom_addr   (rom_addr),
    .rom_dout   (rom_dout),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_ready  (out_ready),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  logic [15:0] rom [16];
  always_ff @(posedge clk) if (rom_en) rom_dout <= rom[rom_addr];

  int          n_vec  = 0;
  int          n_fail = 0;
  int          cyc    = 0;
  logic [15:0] exp_q [$];
  logic [15:0] got_q [$];
  int          popc_q [$];
  logic [3:0]  addr_q [$];
  int          done_cnt, en_cnt, done_cyc;
  logic        done_pop;
  logic [15:0] done_word;

  task automatic clear_obs();
    exp_q.delete(); got_q.delete(); popc_q.delete(); addr_q.delete();
    done_cnt = 0; en_cnt = 0; done_cyc = -1; done_pop = 1'b0; done_word = '0;
  endtask

  // One cycle: drive inputs at the falling edge, then record what the DUT presents.
  task automatic tick(input logic rdy, input logic st, input logic ab);
    @(negedge clk);
    out_ready = rdy; start = st; abort = ab;
    #1;
    cyc++;
    if (rom_en) begin en_cnt++; addr_q.push_back(rom_addr); end
    if (out_valid && out_ready) begin got_q.push_back(out_data); popc_q.push_back(cyc); end
    if (done) begin
      done_cnt++; done_cyc = cyc; done_pop = out_valid & out_ready; done_word = out_data;
    end
  endtask

  task automatic test_reset();
    n_vec++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", out_valid); end
    n_vec++; if (out_data !== 16'h0) begin n_fail++; $display("FAIL rst_data: got %h want 0000", out_data); end
    n_vec++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy); end
    n_vec++; if (done !== 1'b0) begin n_fail++; $display("FAIL rst_done: got %b want 0", done); end
    n_vec++; if (rom_en !== 1'b0) begin n_fail++; $display("FAIL rst_en: got %b want 0", rom_en); end
    n_vec++; if (rom_addr !== 4'h0) begin n_fail++; $display("FAIL rst_addr: got %h want 0", rom_addr); end
  endtask

  task automatic test_basic();
    int s;
    logic [15:0] w, e;
    clear_obs();
    start_addr = 4'd0; len = 5'd3;
    for (int i = 0; i < 3; i++) exp_q.push_back(rom[i]);
    tick(1'b1, 1'b1, 1'b0);
    s = cyc;
    for (int i = 0; i < 20 && done_cnt == 0; i++) tick(1'b1, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0);
    n_vec++; if (got_q.size() != 3) begin n_fail++; $display("FAIL t1_count: got %0d want 3", got_q.size()); end
    while (got_q.size() != 0 && exp_q.size() != 0) begin
      w = got_q.pop_front(); e = exp_q.pop_front();
      n_vec++; if (w !== e) begin n_fail++; $display("FAIL t1_word: got %h want %h", w, e); end
    end
    n_vec++; if (popc_q.size() < 3 || popc_q[0] != s + 3 || popc_q[2] != s + 5) begin
      n_fail++; $display("FAIL t1_timing: first pop cycle %0d want %0d",
                         popc_q.size() > 0 ? popc_q[0] - s : -1, 3);
    end
    n_vec++; if (done_cnt != 1 || !done_pop || done_word !== 16'h8101) begin
      n_fail++; $display("FAIL t1_done: count %0d word %h want 1 with 8101", done_cnt, done_word);
    end
  endtask

  task automatic test_wrap();
    logic [15:0] w, e;
    clear_obs();
    start_addr = 4'd15; len = 5'd2;
    exp_q.push_back(16'h4002); exp_q.push_back(16'h200A);
    tick(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 20 && done_cnt == 0; i++) tick(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 1'b0);
    n_vec++; if (addr_q.size() != 2 || addr_q[0] !== 4'd15 || addr_q[1] !== 4'd0) begin
      n_fail++; $display("FAIL t2_addr: got %0d reads want 15 then 0", addr_q.size());
    end
    n_vec++; if (got_q.size() != 2) begin n_fail++; $display("FAIL t2_count: got %0d want 2", got_q.size()); end
    while (got_q.size() != 0 && exp_q.size() != 0) begin
      w = got_q.pop_front(); e = exp_q.pop_front();
      n_vec++; if (w !== e) begin n_fail++; $display("FAIL t2_word: got %h want %h", w, e); end
    end
    n_vec++; if (done_cnt != 1) begin n_fail++; $display("FAIL t2_done: got %0d pulses want 1", done_cnt); end
  endtask

  task automatic test_backpressure();
    logic [15:0] w, e;
    clear_obs();
    start_addr = 4'd0; len = 5'd4;
    for (int i = 0; i < 4; i++) exp_q.push_back(rom[i]);
    tick(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) begin
      tick(1'b0, 1'b0, 1'b0);
      if (out_valid) begin
        n_vec++; if (out_data !== 16'h200A) begin
          n_fail++; $display("FAIL t3_hold: got %h want 200A", out_data);
        end
      end
    end
    n_vec++; if (en_cnt != 2) begin n_fail++; $display("FAIL t3_credit: got %0d reads want 2", en_cnt); end
    n_vec++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL t3_valid: got %b want 1", out_valid); end
    for (int i = 0; i < 20 && done_cnt == 0; i++) tick(1'b1, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0);
    n_vec++; if (got_q.size() != 4) begin n_fail++; $display("FAIL t3_count: got %0d want 4", got_q.size()); end
    while (got_q.size() != 0 && exp_q.size() != 0) begin
      w = got_q.pop_front(); e = exp_q.pop_front();
      n_vec++; if (w !== e) begin n_fail++; $display("FAIL t3_word: got %h want %h", w, e); end
    end
  endtask

  task automatic test_full_random();
    logic [15:0] w, e;
    logic [3:0] a;
    clear_obs();
    start_addr = 4'd4; len = 5'd16;
    for (int i = 0; i < 16; i++) begin a = 4'(4 + i); exp_q.push_back(rom[a]); end
    tick(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 200 && done_cnt == 0; i++) tick(1'($urandom_range(0, 1)), 1'b0, 1'b0);
    n_vec++; if (got_q.size() != 16) begin n_fail++; $display("FAIL t4_count: got %0d want 16", got_q.size()); end
    while (got_q.size() != 0 && exp_q.size() != 0) begin
      w = got_q.pop_front(); e = exp_q.pop_front();
      n_vec++; if (w !== e) begin n_fail++; $display("FAIL t4_word: got %h want %h", w, e); end
    end
    tick(1'b1, 1'b0, 1'b0);
    n_vec++; if (done_cnt != 1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL t4_done: pulses %0d busy %b want 1 and 0", done_cnt, busy);
    end
  endtask

  task automatic test_abort();
    logic [15:0] w, e;
    clear_obs();
    start_addr = 4'd0; len = 5'd3;
    tick(1'b0, 1'b1, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b1);
    tick(1'b1, 1'b0, 1'b0);
    n_vec++; if (out_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL t5_flush: valid %b busy %b want 0 0", out_valid, busy);
    end
    for (int i = 0; i < 4; i++) tick(1'b1, 1'b0, 1'b0);
    n_vec++; if (done_cnt != 0 || got_q.size() != 0) begin
      n_fail++; $display("FAIL t5_aborted: done %0d words %0d want 0 0", done_cnt, got_q.size());
    end
    clear_obs();
    start_addr = 4'd8; len = 5'd1;
    exp_q.push_back(16'h2222);
    tick(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 20 && done_cnt == 0; i++) tick(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 1'b0);
    n_vec++; if (got_q.size() != 1 || done_cnt != 1) begin
      n_fail++; $display("FAIL t5_restart: words %0d done %0d want 1 1", got_q.size(), done_cnt);
    end
    while (got_q.size() != 0 && exp_q.size() != 0) begin
      w = got_q.pop_front(); e = exp_q.pop_front();
      n_vec++; if (w !== e) begin n_fail++; $display("FAIL t5_word: got %h want %h", w, e); end
    end
  endtask

  task automatic test_async_reset_and_zero_len();
    int s;
    clear_obs();
    start_addr = 4'd0; len = 5'd4;
    tick(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1;
    n_vec++; if (busy !== 1'b0 || rom_en !== 1'b0 || done !== 1'b0) begin
      n_fail++; $display("FAIL t6_rst_ctl: busy %b en %b done %b want 0 0 0", busy, rom_en, done);
    end
    n_vec++; if (out_valid !== 1'b0 || out_data !== 16'h0 || rom_addr !== 4'h0) begin
      n_fail++; $display("FAIL t6_rst_out: valid %b data %h addr %h want 0 0000 0",
                         out_valid, out_data, rom_addr);
    end
    @(negedge clk); rst = 1'b0;
    clear_obs();
    len = 5'd0;
    tick(1'b1, 1'b1, 1'b0);
    s = cyc;
    for (int i = 0; i < 4; i++) tick(1'b1, 1'b0, 1'b0);
    n_vec++; if (done_cnt != 1 || done_cyc != s + 1) begin
      n_fail++; $display("FAIL t6_zero_done: pulses %0d at +%0d want 1 at +1", done_cnt, done_cyc - s);
    end
    n_vec++; if (en_cnt != 0) begin n_fail++; $display("FAIL t6_zero_en: got %0d reads want 0", en_cnt); end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) rom[i] = 16'h1000 + 16'(i) * 16'h0111;
    rom[0] = 16'h200A; rom[1] = 16'h0300; rom[2] = 16'h8101; rom[3] = 16'h4000;
    rom[4] = 16'h8601; rom[8] = 16'h2222; rom[15] = 16'h4002;
    rst = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b0;
    start_addr = 4'd0; len = 5'd0;
    #3;
    test_reset();
    @(negedge clk); rst = 1'b0;
    test_basic();
    test_wrap();
    test_backpressure();
    test_full_random();
    test_abort();
    test_async_reset_and_zero_len();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
